// File: rtl/collision_scheduler.sv
// collision_scheduler: car position table with round-robin update arbitration and a sequential pairwise collision scan
module collision_scheduler #(
  parameter int NUM_CARS = 12,
  parameter int IDX_W    = 4,
  parameter int LONG     = 60,
  parameter int SHORT    = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CARS-1:0]    upd_req,
  input  logic [NUM_CARS*10-1:0] upd_x,
  input  logic [NUM_CARS*10-1:0] upd_y,
  input  logic [NUM_CARS*2-1:0]  upd_orient,
  output logic [NUM_CARS-1:0]    upd_ack,
  input  logic                   scan_start,
  output logic                   busy,
  output logic                   done,
  output logic                   collision,
  output logic [IDX_W-1:0]       col_a,
  output logic [IDX_W-1:0]       col_b
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, nextState;
  logic [9:0] xTab [NUM_CARS];
  logic [9:0] yTab [NUM_CARS];
  logic [NUM_CARS-1:0] vert, valid;
  logic [IDX_W-1:0] rrPtr, pairI, pairJ, grantIdx;
  logic grantVld, doGrant, hit, lastPair, startScan;
  logic [10:0] xi, xj, yi, yj, wi, wj, hi, hj;
  logic unusedOrient;
  assign unusedOrient = ^upd_orient;
  // round-robin pick: lowest requesting slot at or after rrPtr, wrapping
  always_comb begin
    int s;
    s = 0;
    grantVld = 1'b0;
    grantIdx = '0;
    for (int o = NUM_CARS - 1; o >= 0; o--) begin
      s = int'(rrPtr) + o;
      if (s >= NUM_CARS) s = s - NUM_CARS;
      if (upd_req[s]) begin
        grantVld = 1'b1;
        grantIdx = IDX_W'(s);
      end
    end
  end
  assign startScan = state == IDLE && scan_start;
  assign doGrant   = rst_n && state == IDLE && !scan_start && grantVld;
  assign upd_ack   = doGrant ? NUM_CARS'(1) << grantIdx : '0;
  assign busy      = state == SCAN;
  assign done      = state == DONE;
  // half-open box test for the current pair; width/height swap with orientation
  always_comb begin
    xi = {1'b0, xTab[pairI]};
    xj = {1'b0, xTab[pairJ]};
    yi = {1'b0, yTab[pairI]};
    yj = {1'b0, yTab[pairJ]};
    wi = vert[pairI] ? 11'(SHORT) : 11'(LONG);
    wj = vert[pairJ] ? 11'(SHORT) : 11'(LONG);
    hi = vert[pairI] ? 11'(LONG) : 11'(SHORT);
    hj = vert[pairJ] ? 11'(LONG) : 11'(SHORT);
    hit = valid[pairI] && valid[pairJ] && xi < xj + wj && xj < xi + wi && yi < yj + hj && yj < yi + hi;
    lastPair = pairI == IDX_W'(NUM_CARS - 2) && pairJ == IDX_W'(NUM_CARS - 1);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // next state: scan ends on first hit or after the last pair, DONE is a single cycle
  always_comb begin
    nextState = state;
    if (startScan) nextState = SCAN;
    else if (state == SCAN && (hit || lastPair)) nextState = DONE;
    else if (state == DONE) nextState = IDLE;
  end
  // table writes, pair sequencing and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        xTab[k] <= '0;
        yTab[k] <= '0;
      end
      vert      <= '0;
      valid     <= '0;
      rrPtr     <= '0;
      pairI     <= '0;
      pairJ     <= IDX_W'(1);
      collision <= 1'b0;
      col_a     <= '0;
      col_b     <= '0;
    end else begin
      if (doGrant) begin
        xTab[grantIdx]  <= upd_x[grantIdx*10 +: 10];
        yTab[grantIdx]  <= upd_y[grantIdx*10 +: 10];
        vert[grantIdx]  <= upd_orient[grantIdx*2];
        valid[grantIdx] <= 1'b1;
        rrPtr <= grantIdx == IDX_W'(NUM_CARS - 1) ? '0 : grantIdx + 1'b1;
      end
      if (startScan) begin
        collision <= 1'b0;
        col_a     <= '0;
        col_b     <= '0;
        pairI     <= '0;
        pairJ     <= IDX_W'(1);
      end
      if (state == SCAN) begin
        if (hit) begin
          collision <= 1'b1;
          col_a     <= pairI;
          col_b     <= pairJ;
        end else if (!lastPair) begin
          pairI <= pairJ == IDX_W'(NUM_CARS - 1) ? pairI + 1'b1 : pairI;
          pairJ <= pairJ == IDX_W'(NUM_CARS - 1) ? pairI + IDX_W'(2) : pairJ + 1'b1;
        end
      end
    end
endmodule
